uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, 8N1 framing (1 start, 8 data LSB-first, 1 stop), the receive counterpart of the team's uart_tx.
- Samples asynchronous rxd_in at mid-bit using a clock-count baud timer.
- Presents each received byte on a one-entry valid/ready output buffer.
- Reports framing and overrun errors as single-cycle pulses.
- Sits between the board RX pin and the consuming logic (FIFO/CPU bridge).

Parameters:
CLK_RATE, 50000000, clk frequency in Hz
BAUD_RATE, 115200, line rate in bits/s; CLKS_PER_BAUD = integer(CLK_RATE/BAUD_RATE), truncating; HALF_BAUD = CLKS_PER_BAUD/2, truncating

Ports:
clk  input  1  clock
areset  input  1  asynchronous, active-high reset
rxd_in  input  1  serial line, idle high, asynchronous to clk
data_read_ready  input  1  consumer accepts data_out this cycle
data_read_valid  output  1  data_out holds an unread byte
data_out  output  8  received byte
frame_error  output  1  one-cycle pulse: stop bit sampled low
overrun_error  output  1  one-cycle pulse: completed byte dropped because buffer full

Behaviour:
- Reset: clk is the clock; areset is the reset, asynchronous, active-high.
  - Reset values: data_out=0, data_read_valid=0, frame_error=0, overrun_error=0, state IDLE, counters 0, synchronizer flops=1.
  - Reset mid-frame aborts the frame; no partial byte is ever delivered.
- Input sync: rxd_in passes through 2 flops (rx_s). All decisions use rx_s only.
- States:
  - IDLE: rx_s==0 -> START, clk_cnt=0.
  - START: clk_cnt increments each cycle. When clk_cnt==HALF_BAUD-1, sample rx_s:
    - rx_s==0 -> DATA, clk_cnt=0, bit_cnt=0.
    - rx_s==1 -> glitch; return to IDLE, no output.
  - DATA: clk_cnt==CLKS_PER_BAUD-1 -> sample rx_s into shift_reg[bit_cnt], clk_cnt=0, bit_cnt++. After the bit_cnt==7 sample -> STOP.
  - STOP: clk_cnt==CLKS_PER_BAUD-1 -> sample rx_s:
    - rx_s==1 -> deliver byte, go to IDLE.
    - rx_s==0 -> frame_error pulse, byte discarded, go to BREAK.
  - BREAK: wait for rx_s==1, then IDLE. A held-low line therefore never re-triggers START.
- Sampling: the sample points are mid-bit. The first data bit is sampled HALF_BAUD+CLKS_PER_BAUD cycles after rx_s falls.
- Output buffer (one entry):
  - A transfer occurs when data_read_valid && data_read_ready; the buffer then clears on the next edge unless a delivery refills it.
  - Delivery with buffer empty: data_out<=byte, data_read_valid<=1 on the edge after the stop sample.
  - Delivery with buffer full and no transfer that cycle: overrun_error pulse. The old byte is kept and the new byte dropped.
  - Delivery and transfer in the same cycle: new byte loaded, valid stays 1, no overrun.
  - data_out is stable while data_read_valid=1 and no transfer has occurred.
  - data_read_ready is ignored while valid=0.
- Error pulses are exactly one cycle wide and never both high in the same cycle.
- Latency: data_read_valid rises 2+HALF_BAUD+9*CLKS_PER_BAUD cycles (+/-1) after the rxd_in falling edge of the start bit.
- Counter widths: clk_cnt is wide enough for CLKS_PER_BAUD-1 (32 bits acceptable); bit_cnt is 3 bits.

Test Plan:
All scenarios use CLK_RATE=16, BAUD_RATE=1 (CLKS_PER_BAUD=16, HALF_BAUD=8).
- Send 0xA5 frame, ready held high -> one valid pulse with data_out=0xA5, within 2+8+144 +/-1 cycles of the start edge; no errors.
- Send 0x00 then 0xFF back-to-back (stop directly followed by start), ready high -> 0x00 then 0xFF delivered in order; no errors.
- Ready low, send 0x11 then 0x22 -> valid=1 with data_out=0x11, one overrun_error pulse at the second stop, data_out stays 0x11; raise ready -> 0x11 consumed, valid drops.
- Send 0x3C with stop bit 0, hold line low 40 cycles, then a 0x7E frame -> one frame_error pulse, no 0x3C delivered, no spurious start during low hold, 0x7E delivered.
- Low glitch of 5 cycles on rxd_in -> no valid, no errors; the next 0x81 frame is received correctly.
- Assert areset mid-DATA of a frame, release, send 0x5A -> all outputs 0 during reset, only 0x5A delivered afterwards.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (1 start, 8 data LSB-first, 1 stop).
//
// Ports:
//   clk             - clock
//   areset          - asynchronous, active-high reset
//   rxd_in          - serial line, idle high, asynchronous to clk
//   data_read_ready - consumer accepts data_out this cycle
//   data_read_valid - data_out holds an unread byte
//   data_out        - received byte
//   frame_error     - one-cycle pulse: stop bit sampled low
//   overrun_error   - one-cycle pulse: completed byte dropped, buffer full
//
// rxd_in is double-flopped into rx_s; every decision uses rx_s. A clock-count
// baud timer places each sample at mid-bit. Received bytes go to a one-entry
// valid/ready buffer.
module uart_rx #(
    parameter int unsigned CLK_RATE  = 50000000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       rxd_in,
    input  logic       data_read_ready,
    output logic       data_read_valid,
    output logic [7:0] data_out,
    output logic       frame_error,
    output logic       overrun_error
);

    localparam int unsigned ClksPerBaud = CLK_RATE / BAUD_RATE;
    localparam int unsigned HalfBaud    = ClksPerBaud / 2;
    localparam logic [31:0] BaudLast    = 32'(ClksPerBaud - 1);
    localparam logic [31:0] HalfLast    = 32'(HalfBaud - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [31:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_q, valid_d;
    logic        frame_error_q, frame_error_d;
    logic        overrun_error_q, overrun_error_d;

    logic half_tick, baud_tick, stop_sample, transfer;

    assign half_tick   = (clk_cnt_q == HalfLast);
    assign baud_tick   = (clk_cnt_q == BaudLast);
    assign stop_sample = (state_q == StStop) && baud_tick;
    assign transfer    = valid_q && data_read_ready;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rxd_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (!rx_s_q) state_d = StStart;
            // A start bit that is high again at its midpoint was a glitch.
            StStart: if (half_tick) state_d = rx_s_q ? StIdle : StData;
            StData:  if (baud_tick && (bit_cnt_q == 3'd7)) state_d = StStop;
            StStop:  if (baud_tick) state_d = rx_s_q ? StIdle : StBreak;
            // Held-low line after a bad stop bit must not look like a new start.
            StBreak: if (rx_s_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Counters, shift register and output buffer.
    always_comb begin
        clk_cnt_d       = clk_cnt_q + 32'd1;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        data_out_d      = data_out_q;
        valid_d         = valid_q;
        frame_error_d   = 1'b0;
        overrun_error_d = 1'b0;

        case (state_q)
            StStart: begin
                if (half_tick) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (baud_tick) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_cnt_q] = rx_s_q;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                end
            end
            StStop: begin
                if (baud_tick) clk_cnt_d = '0;
            end
            default: clk_cnt_d = '0;
        endcase

        if (transfer) valid_d = 1'b0;

        if (stop_sample) begin
            if (!rx_s_q) begin
                frame_error_d = 1'b1;
            end else if (!valid_q || transfer) begin
                // Empty buffer, or being emptied this cycle: load the new byte.
                data_out_d = shift_q;
                valid_d    = 1'b1;
            end else begin
                overrun_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            clk_cnt_q       <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            data_out_q      <= '0;
            valid_q         <= 1'b0;
            frame_error_q   <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            clk_cnt_q       <= clk_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            data_out_q      <= data_out_d;
            valid_q         <= valid_d;
            frame_error_q   <= frame_error_d;
            overrun_error_q <= overrun_error_d;
        end
    end

    assign data_read_valid = valid_q;
    assign data_out        = data_out_q;
    assign frame_error     = frame_error_q;
    assign overrun_error   = overrun_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames for uart_rx, checked every cycle
// against a transaction-level model (frame outcome scheduled at a fixed
// latency after the start edge, plus a one-entry buffer).
module tb_uart_rx;

    localparam int unsigned Cpb  = 16;
    localparam int unsigned Half = 8;
    localparam int          Lat  = 2 + Half + 9 * Cpb;  // 154

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic       rxd_in = 1'b1;
    logic       ready = 1'b0;
    logic       valid;
    logic [7:0] dout;
    logic       ferr;
    logic       oerr;

    uart_rx #(
        .CLK_RATE (16),
        .BAUD_RATE(1)
    ) dut (
        .clk            (clk),
        .areset         (areset),
        .rxd_in         (rxd_in),
        .data_read_ready(ready),
        .data_read_valid(valid),
        .data_out       (dout),
        .frame_error    (ferr),
        .overrun_error  (oerr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- model ----------------
    typedef struct packed {
        int         tick;
        logic       ok;
        logic [7:0] b;
    } ev_t;
    ev_t evq[$];

    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_ferr = 1'b0;
    logic       m_oerr = 1'b0;

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_ferr  <= 1'b0;
            m_oerr  <= 1'b0;
            evq.delete();
        end else begin
            m_ferr <= 1'b0;
            m_oerr <= 1'b0;
            if (m_valid && ready) m_valid <= 1'b0;
            if (evq.size() > 0) begin
                if (evq[0].tick <= cyc) begin
                    if (!evq[0].ok) begin
                        m_ferr <= 1'b1;
                    end else if (!m_valid || ready) begin
                        m_valid <= 1'b1;
                        m_data  <= evq[0].b;
                    end else begin
                        m_oerr <= 1'b1;
                    end
                    void'(evq.pop_front());
                end
            end
        end
    end

    // ---------------- monitor / per-cycle compare ----------------
    logic [7:0] got[$];
    int n_fe = 0;
    int n_oe = 0;
    int rise_cyc = 0;
    logic prev_v = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            n_cmp++;
            if (valid !== m_valid || ferr !== m_ferr || oerr !== m_oerr ||
                ((m_valid || areset) && dout !== m_data)) begin
                n_bad++;
                $display("FAIL cycle_%0d outputs: dut v=%b d=%h fe=%b oe=%b, model v=%b d=%h fe=%b oe=%b",
                         cyc, valid, dout, ferr, oerr, m_valid, m_data, m_ferr, m_oerr);
            end
            if (valid === 1'b1 && ready === 1'b1) got.push_back(dout);
            if (ferr === 1'b1) n_fe++;
            if (oerr === 1'b1) n_oe++;
            if (valid === 1'b1 && prev_v !== 1'b1) rise_cyc = cyc;
            prev_v = valid;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxd_in = 1'b1;
        wait_cycles(n);
    endtask

    // Leaves the line at the stop-bit level; caller restores idle.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        evq.push_back('{tick: cyc + Lat, ok: stop, b: b});
        rxd_in = 1'b0;
        wait_cycles(Cpb);
        for (int i = 0; i < 8; i++) begin
            rxd_in = b[i];
            wait_cycles(Cpb);
        end
        rxd_in = stop;
        wait_cycles(Cpb);
    endtask

    task automatic clear_log();
        got.delete();
        n_fe = 0;
        n_oe = 0;
    endtask

    bit rnd_ready = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) ready = 1'($urandom_range(0, 1));
        end
    end

    int t0;
    logic [7:0] rb;
    logic       rs;

    initial begin
        wait_cycles(3);
        check("reset_valid", int'(valid), 0);
        check("reset_data", int'(dout), 0);
        check("reset_errors", int'({ferr, oerr}), 0);
        areset = 1'b0;
        idle(10);

        // 0xA5 with ready high, latency check
        clear_log();
        ready = 1'b1;
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("a5_count", got.size(), 1);
        if (got.size() > 0) check("a5_byte", int'(got[0]), 'hA5);
        check("a5_latency", int'((rise_cyc - t0 >= Lat - 1) && (rise_cyc - t0 <= Lat + 1)), 1);
        check("a5_errors", n_fe + n_oe, 0);

        // back-to-back 0x00, 0xFF
        clear_log();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        check("b2b_count", got.size(), 2);
        if (got.size() == 2) begin
            check("b2b_first", int'(got[0]), 'h00);
            check("b2b_second", int'(got[1]), 'hFF);
        end
        check("b2b_errors", n_fe + n_oe, 0);

        // overrun: ready low
        clear_log();
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(10);
        check("ovr_valid", int'(valid), 1);
        check("ovr_data", int'(dout), 'h11);
        check("ovr_pulses", n_oe, 1);
        ready = 1'b1;
        wait_cycles(3);
        check("ovr_drained", int'(valid), 0);
        check("ovr_consumed", got.size(), 1);
        if (got.size() > 0) check("ovr_byte", int'(got[0]), 'h11);

        // bad stop bit, line held low, then good frame
        clear_log();
        send_frame(8'h3C, 1'b0);
        wait_cycles(24);
        idle(20);
        send_frame(8'h7E, 1'b1);
        idle(20);
        check("fe_pulses", n_fe, 1);
        check("fe_count", got.size(), 1);
        if (got.size() > 0) check("fe_byte", int'(got[0]), 'h7E);

        // 5-cycle glitch, then 0x81
        clear_log();
        rxd_in = 1'b0;
        wait_cycles(5);
        idle(30);
        check("glitch_nothing", got.size() + n_fe + n_oe, 0);
        send_frame(8'h81, 1'b1);
        idle(20);
        check("glitch_count", got.size(), 1);
        if (got.size() > 0) check("glitch_byte", int'(got[0]), 'h81);

        // reset mid-DATA (frame not scheduled: it must never arrive)
        clear_log();
        rxd_in = 1'b0;
        wait_cycles(Cpb);
        rxd_in = 1'b1;
        wait_cycles(Cpb);
        rxd_in = 1'b0;
        wait_cycles(10);
        areset = 1'b1;
        rxd_in = 1'b1;
        wait_cycles(2);
        check("rst_valid", int'(valid), 0);
        check("rst_data", int'(dout), 0);
        check("rst_errors", int'({ferr, oerr}), 0);
        areset = 1'b0;
        idle(20);
        send_frame(8'h5A, 1'b1);
        idle(20);
        check("rst_count", got.size(), 1);
        if (got.size() > 0) check("rst_byte", int'(got[0]), 'h5A);
        check("rst_errors_after", n_fe + n_oe, 0);

        // randomized frames, random ready, occasional bad stop bit
        rnd_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            send_frame(rb, rs);
            if (!rs) wait_cycles($urandom_range(0, 20));
            idle($urandom_range(2, 30));
        end
        rnd_ready = 1'b0;
        ready = 1'b1;
        idle(10);
        check("events_drained", evq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
